// File: rtl/grid_pkg.sv
// Shared colours, stage-1 payload and boundary helper for the grid renderer.
package grid_pkg;

  localparam int unsigned COLOR_W = 24;

  typedef logic [COLOR_W-1:0] rgb_t;

  localparam rgb_t COL_GOLD     = 24'hF9C700;
  localparam rgb_t COL_PURP     = 24'h6600CC;
  localparam rgb_t COL_EMPTY    = 24'hFFFFFF;
  localparam rgb_t COL_LINE     = 24'h000000;
  localparam rgb_t COL_CURSOR   = 24'h00FF00;
  localparam rgb_t COL_CONFLICT = 24'hFF0000;
  localparam rgb_t COL_BLACK    = 24'h000000;

  // Per-pixel attributes captured in stage 1 and consumed by the colour stage.
  typedef struct packed {
    logic in_view;
    logic in_grid;
    logic on_line;
    logic cur_hit;
    logic purp;
    logic gold;
    logic win;
  } pix_t;

  // Start coordinate of cell k along an axis of res pixels split into n cells.
  function automatic int unsigned grid_bound(int unsigned k, int unsigned res, int unsigned n);
    return k * (res / n);
  endfunction

endpackage

// File: rtl/grid_locate.sv
// Combinational pixel locator: maps x/y to cell column/row and edge flags
// using constant boundary comparisons only (no dividers).
module grid_locate
  import grid_pkg::*;
#(
  parameter int unsigned H_RES  = 640,
  parameter int unsigned V_RES  = 480,
  parameter int unsigned COLS   = 3,
  parameter int unsigned ROWS   = 3,
  parameter int unsigned LINE_W = 4
) (
  input  logic [9:0] x,
  input  logic [8:0] y,
  output logic [2:0] col_c,
  output logic [2:0] row_c,
  output logic       on_line_c,
  output logic       on_cur_edge_c,
  output logic       in_view_c,
  output logic       in_grid_c
);

  localparam int unsigned CW   = H_RES / COLS;
  localparam int unsigned CH   = V_RES / ROWS;
  localparam int unsigned HALF = LINE_W / 2;

  logic x_line, x_edge, y_line, y_edge;

  // Horizontal axis: column, interior grid lines, own-cell left/right edges.
  always_comb begin
    col_c  = '0;
    x_line = 1'b0;
    x_edge = 1'b0;
    for (int unsigned k = 1; k < COLS; k++) begin
      if (x >= 10'(grid_bound(k, H_RES, COLS))) col_c = 3'(k);
      if (({1'b0, x} + 11'(HALF) >= {1'b0, 10'(grid_bound(k, H_RES, COLS))}) &&
          ({1'b0, x} <  {1'b0, 10'(grid_bound(k, H_RES, COLS))} + 11'(LINE_W - HALF)))
        x_line = 1'b1;
    end
    for (int unsigned k = 0; k < COLS; k++) begin
      if ((x >= 10'(grid_bound(k, H_RES, COLS))) && (x < 10'(grid_bound(k + 1, H_RES, COLS)))) begin
        if (({1'b0, x} <  {1'b0, 10'(grid_bound(k, H_RES, COLS))} + 11'(LINE_W)) ||
            ({1'b0, x} + 11'(LINE_W) >= {1'b0, 10'(grid_bound(k + 1, H_RES, COLS))}))
          x_edge = 1'b1;
      end
    end
  end

  // Vertical axis: row, interior grid lines, own-cell top/bottom edges.
  always_comb begin
    row_c  = '0;
    y_line = 1'b0;
    y_edge = 1'b0;
    for (int unsigned k = 1; k < ROWS; k++) begin
      if (y >= 9'(grid_bound(k, V_RES, ROWS))) row_c = 3'(k);
      if (({1'b0, y} + 10'(HALF) >= {1'b0, 9'(grid_bound(k, V_RES, ROWS))}) &&
          ({1'b0, y} <  {1'b0, 9'(grid_bound(k, V_RES, ROWS))} + 10'(LINE_W - HALF)))
        y_line = 1'b1;
    end
    for (int unsigned k = 0; k < ROWS; k++) begin
      if ((y >= 9'(grid_bound(k, V_RES, ROWS))) && (y < 9'(grid_bound(k + 1, V_RES, ROWS)))) begin
        if (({1'b0, y} <  {1'b0, 9'(grid_bound(k, V_RES, ROWS))} + 10'(LINE_W)) ||
            ({1'b0, y} + 10'(LINE_W) >= {1'b0, 9'(grid_bound(k + 1, V_RES, ROWS))}))
          y_edge = 1'b1;
      end
    end
  end

  // Visibility and remainder-strip flags plus combined line/edge flags.
  always_comb begin
    in_view_c     = (x < 10'(H_RES)) && (y < 9'(V_RES));
    in_grid_c     = (x < 10'(COLS * CW)) && (y < 9'(ROWS * CH));
    on_line_c     = x_line | y_line;
    on_cur_edge_c = x_edge | y_edge;
  end

endmodule

// File: rtl/grid_renderer.sv
// Two-stage pixel colour pipeline for a ROWS x COLS tic-tac-toe board with
// grid lines, cursor outline and blinking winning cells.
module grid_renderer
  import grid_pkg::*;
#(
  parameter int unsigned H_RES        = 640,
  parameter int unsigned V_RES        = 480,
  parameter int unsigned COLS         = 3,
  parameter int unsigned ROWS         = 3,
  parameter int unsigned LINE_W       = 4,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [9:0]           x,
  input  logic [8:0]           y,
  input  logic [ROWS*COLS-1:0] purp,
  input  logic [ROWS*COLS-1:0] gold,
  input  logic [ROWS*COLS-1:0] win,
  input  logic [5:0]           cursor,
  input  logic                 cursor_en,
  output logic [7:0]           r,
  output logic [7:0]           g,
  output logic [7:0]           b
);

  localparam int unsigned N  = ROWS * COLS;
  localparam int unsigned BW = $clog2(BLINK_FRAMES + 1);

  logic [2:0] col_c, row_c;
  logic       on_line_c, on_cur_edge_c, in_view_c, in_grid_c;
  logic [5:0] idx_c;
  logic       frame_c;
  pix_t       s1_c;
  pix_t       s1;
  logic       s1_zero;
  logic [BW-1:0] blink_cnt;
  logic       blink_phase;
  rgb_t       colour_c;

  grid_locate #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .COLS  (COLS),
    .ROWS  (ROWS),
    .LINE_W(LINE_W)
  ) u_locate (
    .x            (x),
    .y            (y),
    .col_c        (col_c),
    .row_c        (row_c),
    .on_line_c    (on_line_c),
    .on_cur_edge_c(on_cur_edge_c),
    .in_view_c    (in_view_c),
    .in_grid_c    (in_grid_c)
  );

  // Stage-1 payload: select this pixel's cell state alongside its geometry.
  always_comb begin
    idx_c        = 6'(32'(row_c) * COLS + 32'(col_c));
    frame_c      = (x == 10'd0) && (y == 9'd0);
    s1_c         = '0;
    s1_c.in_view = in_view_c;
    s1_c.in_grid = in_grid_c;
    s1_c.on_line = on_line_c;
    s1_c.cur_hit = cursor_en && (cursor == idx_c) && on_cur_edge_c;
    for (int unsigned i = 0; i < N; i++) begin
      if (idx_c == 6'(i)) begin
        s1_c.purp = purp[i];
        s1_c.gold = gold[i];
        s1_c.win  = win[i];
      end
    end
  end

  // Stage-1 register and 0,0 dwell tracker.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1      <= '0;
      s1_zero <= 1'b0;
    end else begin
      s1      <= s1_c;
      s1_zero <= frame_c;
    end
  end

  // Blink counter: advances only on the first cycle of each 0,0 dwell.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_c && !s1_zero) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  // Colour priority resolution for the stage-1 pixel.
  always_comb begin
    colour_c = COL_EMPTY;
    if (!s1.in_view || !s1.in_grid)     colour_c = COL_BLACK;
    else if (s1.on_line)                colour_c = COL_LINE;
    else if (s1.cur_hit)                colour_c = COL_CURSOR;
    else if (s1.purp && s1.gold)        colour_c = COL_CONFLICT;
    else if (s1.win && blink_phase)     colour_c = COL_EMPTY;
    else if (s1.gold)                   colour_c = COL_GOLD;
    else if (s1.purp)                   colour_c = COL_PURP;
  end

  // Stage-2 output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r <= '0;
      g <= '0;
      b <= '0;
    end else begin
      r <= colour_c[23:16];
      g <= colour_c[15:8];
      b <= colour_c[7:0];
    end
  end

endmodule

// File: tb/tb_grid_renderer.sv
// Directed bench for grid_renderer: default board, fast-blink board, 4x2 board.
module tb_grid_renderer;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] x;
  logic [8:0] y;
  logic [5:0] cursor;
  logic       cursor_en;

  logic [8:0] purp0, gold0, win0;
  logic [8:0] purp1, gold1, win1;
  logic [7:0] purp2, gold2, win2;
  logic [7:0] r0, g0, b0, r1, g1, b1, r2, g2, b2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  grid_renderer dut0 (
    .clk(clk), .reset(reset), .x(x), .y(y),
    .purp(purp0), .gold(gold0), .win(win0),
    .cursor(cursor), .cursor_en(cursor_en),
    .r(r0), .g(g0), .b(b0)
  );

  grid_renderer #(.BLINK_FRAMES(2)) dut1 (
    .clk(clk), .reset(reset), .x(x), .y(y),
    .purp(purp1), .gold(gold1), .win(win1),
    .cursor(cursor), .cursor_en(cursor_en),
    .r(r1), .g(g1), .b(b1)
  );

  grid_renderer #(.COLS(4), .ROWS(2)) dut2 (
    .clk(clk), .reset(reset), .x(x), .y(y),
    .purp(purp2), .gold(gold2), .win(win2),
    .cursor(cursor), .cursor_en(cursor_en),
    .r(r2), .g(g2), .b(b2)
  );

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%06h expected=%06h", tag, got, exp);
    end
  endtask

  // Park on 0,0 for dwell cycles, return to the probe pixel and let it settle.
  task automatic frame(input int dwell);
    x = 10'd0; y = 9'd0;
    cycles(dwell);
    x = 10'd500; y = 9'd400;
    cycles(3);
  endtask

  initial begin
    reset = 1'b1; x = 10'd100; y = 9'd80;
    cursor = 6'd0; cursor_en = 1'b0;
    purp0 = '0; gold0 = '0; win0 = '0;
    purp1 = '0; gold1 = '0; win1 = '0;
    purp2 = '0; gold2 = '0; win2 = '0;

    cycles(3);
    check("reset_black", {r0, g0, b0}, 24'h000000);
    reset = 1'b0;
    cycles(1);
    check("latency_1cyc", {r0, g0, b0}, 24'h000000);
    cycles(1);
    check("latency_2cyc_empty", {r0, g0, b0}, 24'hFFFFFF);

    gold0[4] = 1'b1; x = 10'd320; y = 9'd240;
    cycles(2);
    check("gold_centre", {r0, g0, b0}, 24'hF9C700);
    purp0[4] = 1'b1;
    cycles(2);
    check("conflict", {r0, g0, b0}, 24'hFF0000);
    x = 10'd214;
    cycles(2);
    check("grid_line", {r0, g0, b0}, 24'h000000);

    cursor = 6'd0; cursor_en = 1'b1; x = 10'd2; y = 9'd50;
    cycles(2);
    check("cursor_edge", {r0, g0, b0}, 24'h00FF00);
    x = 10'd100; y = 9'd80;
    cycles(2);
    check("cursor_interior", {r0, g0, b0}, 24'hFFFFFF);
    cursor = 6'd12; x = 10'd2; y = 9'd50;
    cycles(2);
    check("cursor_out_of_range", {r0, g0, b0}, 24'hFFFFFF);
    cursor_en = 1'b0;

    purp0[0] = 1'b1; x = 10'd100; y = 9'd80;
    cycles(2);
    check("purple", {r0, g0, b0}, 24'h6600CC);
    x = 10'd639; y = 9'd100;
    cycles(2);
    check("remainder_strip", {r0, g0, b0}, 24'h000000);
    x = 10'd640;
    cycles(2);
    check("out_of_view", {r0, g0, b0}, 24'h000000);

    win1[8] = 1'b1; gold1[8] = 1'b1; x = 10'd500; y = 9'd400;
    cycles(2);
    check("blink_start", {r1, g1, b1}, 24'hF9C700);
    frame(1);
    check("blink_f1", {r1, g1, b1}, 24'hF9C700);
    frame(1);
    check("blink_f2_off", {r1, g1, b1}, 24'hFFFFFF);
    frame(5);
    check("blink_dwell5", {r1, g1, b1}, 24'hFFFFFF);
    frame(1);
    check("blink_f4_on", {r1, g1, b1}, 24'hF9C700);
    frame(2);
    check("blink_dwell2", {r1, g1, b1}, 24'hF9C700);
    frame(1);
    check("blink_f6_off", {r1, g1, b1}, 24'hFFFFFF);

    reset = 1'b1;
    cycles(1);
    check("reset_mid_blink", {r1, g1, b1}, 24'h000000);
    reset = 1'b0;
    cycles(2);
    check("phase_cleared", {r1, g1, b1}, 24'hF9C700);

    gold2[7] = 1'b1; x = 10'd600; y = 9'd400;
    cycles(2);
    check("4x2_cell7", {r2, g2, b2}, 24'hF9C700);
    x = 10'd639; y = 9'd479;
    cycles(2);
    check("4x2_corner", {r2, g2, b2}, 24'hF9C700);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/grid_renderer.md
Name: grid_renderer

Overview:
Parametrised pixel-colour generator for the tic-tac-toe VGA display. It generalises the fixed 3x3 board renderer to a ROWS x COLS board, and adds grid lines, a cursor outline and blinking winning cells. It sits between the VGA timing driver, which supplies x/y, and the game logic, which supplies the cell states, cursor and win mask. Output is a 2-stage registered pipeline.

Parameters:
H_RES, 640, visible pixels per line
V_RES, 480, visible lines per frame
COLS, 3, board columns (1..8)
ROWS, 3, board rows (1..8)
LINE_W, 4, grid-line and cursor-outline thickness in pixels
BLINK_FRAMES, 30, frames per blink half-period (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
x  in  10  current pixel column
y  in  9  current pixel row
purp  in  ROWS*COLS  purple-owned cells; bit i = row i/COLS, col i%COLS
gold  in  ROWS*COLS  gold-owned cells; same indexing
win  in  ROWS*COLS  cells that are part of the winning line
cursor  in  6  index of the cell under the player cursor
cursor_en  in  1  draw the cursor outline
r  out  8  red
g  out  8  green
b  out  8  blue

Behaviour:
- Reset and synchronicity: reset is synchronous and active-high. While reset is high, on each clk edge:
  - r/g/b are forced to 0;
  - all pipeline registers are cleared;
  - the blink counter is cleared and blink_phase is set to 0.
  After reset deasserts, the first valid colour appears 2 cycles after the x/y it belongs to.
- Cell geometry: cell width CW = H_RES/COLS and cell height CH = V_RES/ROWS, both integer division. Column c spans [c*CW, (c+1)*CW). Pixels beyond COLS*CW or ROWS*CH, the remainder strip, are black.
- Stage 1 (registered):
  - col/row are found by comparing against constant boundaries. No dividers are allowed.
  - in_view = x<H_RES && y<V_RES.
  - on_line = the pixel is within LINE_W of an interior cell boundary. The outer edges are not lines.
  - on_cur_edge = the pixel is within LINE_W of the edges of its own cell.
  - cell_idx = row*COLS+col.
- Stage 2 (registered), colour priority, highest first:
  1. !in_view or remainder strip -> 000000.
  2. on_line -> 000000 (grid line).
  3. cursor_en && cell_idx==cursor && on_cur_edge -> 00FF00.
  4. purp & gold both set -> FF0000 (conflict indicator).
  5. win[cell_idx] && blink_phase -> FFFFFF (blink off).
  6. gold -> F9C700.
  7. purp -> 6600CC.
  8. empty -> FFFFFF.
- Cell state sampling: purp/gold/win/cursor are sampled in stage 1, alongside x/y, so that each output colour is consistent with its pixel.
- Blink counter:
  - A frame start is x==0 && y==0, detected in stage 1. It counts once per frame even if x/y hold at 0,0 for several cycles: only the first cycle of the 0,0 dwell counts.
  - On the BLINK_FRAMES-th frame start, blink_phase toggles and the counter wraps to 0.
- cursor >= ROWS*COLS: no outline is drawn anywhere.
- Width rule: all boundary constants are computed at elaboration, at 10-bit width for x and 9-bit width for y.

Decomposition:
- Package grid_pkg holds:
  - 24-bit colour constants: COL_GOLD, COL_PURP, COL_EMPTY, COL_LINE, COL_CURSOR, COL_CONFLICT;
  - a function that returns the boundary for index k.
- Sub-module grid_locate: coordinate -> {col, row, on_line, on_cur_edge, in_view}. It is combinational and instantiated once for stage 1.

Test Plan:
- Default params, reset held 3 cycles, then x=100, y=80, all masks 0 -> r/g/b=0 during reset; FFFFFF exactly 2 cycles after the x/y is applied.
- gold[4]=1, x=320, y=240 -> F9C700. With purp[4] also set -> FF0000. x=214, y=240 (on the line at 213) -> 000000.
- cursor=0, cursor_en=1, x=2, y=50 -> 00FF00. x=100, y=80 (cell interior) -> FFFFFF. cursor=12 -> no outline at x=2, y=50.
- win[8]=1, gold[8]=1, BLINK_FRAMES=2, x/y held at 500/400 with frame starts pulsed -> colour alternates F9C700 and FFFFFF every 2 frames. A 0,0 dwell of 5 cycles counts as 1 frame.
- COLS=4, ROWS=2, gold[7]=1, x=600, y=400 -> F9C700 (cell 7). x=639, y=479 -> F9C700, since CW=160 leaves no remainder strip.
- Reset asserted mid-blink -> blink_phase returns to 0, and outputs are 0 on the next cycle.
